// File: rtl/ram_bus_responder_if.sv
//------------------------------------------------------------------------------
// Module   : ram_bus_responder_if
// Purpose  : Control/address handshake bundle between the LEGv8 control unit
//            and the RAM bus responder (the 64-bit tristate data net is
//            kept as a separate inout so it can be resolved at the top level).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface ram_bus_responder_if;
    logic [31:0] address;
    logic        CS;
    logic        WE;
    logic        OE;
    logic        ready;
    logic        error;

    modport master (
        output address,
        output CS,
        output WE,
        output OE,
        input  ready,
        input  error
    );

    modport slave (
        input  address,
        input  CS,
        input  WE,
        input  OE,
        output ready,
        output error
    );
endinterface

`default_nettype wire

// File: rtl/ram_bus_responder.sv
//------------------------------------------------------------------------------
// Module   : ram_bus_responder
// Purpose  : 64-bit word memory target on the shared LEGv8 address/data buses
//            with programmable wait states and a registered ready/error pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ram_bus_responder #(
    parameter int          ADDR_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  wire logic          clock,
    input  wire logic          reset,
    ram_bus_responder_if.slave bus,
    inout  wire logic [63:0]   data
);

    localparam int         TAG_LO      = ADDR_WIDTH + 3;
    localparam int         DEPTH       = 2 ** ADDR_WIDTH;
    localparam int         WAIT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0] WAIT_INIT   = WAIT_INIT_I[3:0];
    localparam bit         NO_WAIT     = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              count;
    logic [3:0]              count_next;
    logic [ADDR_WIDTH-1:0]   idx_l;
    logic                    we_l;
    logic                    ok_l;
    logic [63:0]             wdata_l;
    logic [63:0]             rdata;
    logic                    ready_r;
    logic                    error_r;
    logic [63:0]             mem [DEPTH];

    logic                    take;
    logic                    enter_access;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    req_ok;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic                    acc_we;
    logic                    acc_ok;
    logic [63:0]             acc_wdata;
    logic                    drive;

    assign req_idx = bus.address[ADDR_WIDTH+2:3];
    assign req_ok  = (bus.address[31:TAG_LO] == BASE_ADDR[31:TAG_LO]) &&
                     (bus.address[2:0] == 3'b000);

    // With no wait states ACCESS is entered on the sampling edge itself, so
    // the commit must use the live request rather than the latched copy.
    assign acc_idx   = take ? req_idx : idx_l;
    assign acc_we    = take ? bus.WE  : we_l;
    assign acc_ok    = take ? req_ok  : ok_l;
    assign acc_wdata = take ? data    : wdata_l;

    always_comb begin
        state_next   = state;
        count_next   = count;
        take         = 1'b0;
        enter_access = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.CS) begin
                    take = 1'b1;
                    if (NO_WAIT) begin
                        state_next   = S_ACCESS;
                        enter_access = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        count_next = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (count == 4'd0) begin
                    state_next   = S_ACCESS;
                    enter_access = 1'b1;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            S_ACCESS: state_next = bus.CS ? S_HOLD : S_IDLE;
            S_HOLD:   state_next = bus.CS ? S_HOLD : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            idx_l   <= '0;
            we_l    <= 1'b0;
            ok_l    <= 1'b0;
            wdata_l <= 64'd0;
            rdata   <= 64'd0;
            ready_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            // ready/error are a register stage behind the ACCESS state
            ready_r <= (state == S_ACCESS);
            error_r <= (state == S_ACCESS) && !ok_l;
            if (take) begin
                idx_l   <= req_idx;
                we_l    <= bus.WE;
                ok_l    <= req_ok;
                wdata_l <= data;
            end
            if (enter_access && !acc_we && acc_ok) begin
                rdata <= mem[acc_idx];
            end
        end
    end

    // Memory content survives reset; an edge coinciding with reset commits nothing.
    always_ff @(posedge clock) begin
        if (enter_access && acc_we && acc_ok && !reset) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign drive     = ((state == S_ACCESS) || (state == S_HOLD)) && !we_l && ok_l && bus.OE;
    assign data      = drive ? rdata : 64'bz;
    assign bus.ready = ready_r;
    assign bus.error = error_r;

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_ram_bus_responder
// Purpose  : Self-checking bench for ram_bus_responder (0 and 1 wait states).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ram_bus_responder;

    localparam int          AW    = 8;
    localparam logic [63:0] FLOAT = '1;   // tri1 nets read all-ones when undriven
    localparam logic [63:0] DEAD  = 64'hDEAD_BEEF_0123_4567;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_v [2];
    logic        cs_v   [2];
    logic        we_v   [2];
    logic        oe_v   [2];
    logic        wdrv_v [2];
    logic [63:0] wd_v   [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mref   [2][256];
    bit          mknown [2][256];

    always #5 clk = ~clk;

    ram_bus_responder_if bus0 ();
    ram_bus_responder_if bus1 ();
    tri1 [63:0] data0;
    tri1 [63:0] data1;

    assign bus0.address = addr_v[0];
    assign bus0.CS      = cs_v[0];
    assign bus0.WE      = we_v[0];
    assign bus0.OE      = oe_v[0];
    assign bus1.address = addr_v[1];
    assign bus1.CS      = cs_v[1];
    assign bus1.WE      = we_v[1];
    assign bus1.OE      = oe_v[1];
    assign data0 = wdrv_v[0] ? wd_v[0] : 64'bz;
    assign data1 = wdrv_v[1] ? wd_v[1] : 64'bz;

    ram_bus_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
        .clock(clk), .reset(rst), .bus(bus0), .data(data0));
    ram_bus_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_ws1 (
        .clock(clk), .reset(rst), .bus(bus1), .data(data1));

    function automatic logic get_ready(input int d);
        return (d == 0) ? bus0.ready : bus1.ready;
    endfunction
    function automatic logic get_error(input int d);
        return (d == 0) ? bus0.error : bus1.error;
    endfunction
    function automatic logic [63:0] get_data(input int d);
        return (d == 0) ? data0 : data1;
    endfunction

    // Reference model: decode rules and word storage of the target.
    function automatic bit addr_ok(input logic [31:0] a);
        return (a[31:AW+3] == '0) && (a[2:0] == 3'b000);
    endfunction
    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+2:3]);
    endfunction
    function automatic void model_txn(input int d, input logic [31:0] a, input logic w,
                                      input logic [63:0] wv, output logic exp_err,
                                      output logic [63:0] exp_dat);
        exp_err = !addr_ok(a);
        exp_dat = FLOAT;
        if (addr_ok(a)) begin
            if (w) begin
                mref[d][widx(a)]   = wv;
                mknown[d][widx(a)] = 1'b1;
            end else begin
                exp_dat = mref[d][widx(a)];
            end
        end
    endfunction

    // Runs one transaction; reports first ready cycle (cycles after sampling
    // edge), total ready pulses seen, error and bus value at that ready.
    task automatic run_txn(input int d, input logic [31:0] a, input logic w,
                           input logic [63:0] wv, input int hold,
                           output int lat, output int pulses, output logic err,
                           output logic [63:0] rdat);
        lat = -1; pulses = 0; err = 1'b0; rdat = '0;
        @(negedge clk);
        addr_v[d] = a; we_v[d] = w; oe_v[d] = ~w; wd_v[d] = wv; wdrv_v[d] = w; cs_v[d] = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) begin
                wdrv_v[d] = 1'b0;
                addr_v[d] = $urandom;
                we_v[d]   = ~w;
            end
            if (get_ready(d)) begin
                pulses++;
                if (lat < 0) begin
                    lat  = c;
                    err  = get_error(d);
                    rdat = get_data(d);
                end
            end
            if (lat >= 0 && c >= lat + hold) cs_v[d] = 1'b0;
        end
        cs_v[d] = 1'b0; we_v[d] = 1'b0; oe_v[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cs_v[1] = 1'b1; addr_v[1] = 32'h10; oe_v[1] = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_tests++;
            if (get_ready(d) !== 1'b0 || get_error(d) !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flags dut%0d: ready=%b error=%b expected 0/0", d, get_ready(d), get_error(d));
            end
            n_tests++;
            if (get_data(d) !== FLOAT) begin
                n_fail++;
                $display("FAIL reset_bus dut%0d: got %h expected %h", d, get_data(d), FLOAT);
            end
        end
        cs_v[1] = 1'b0; oe_v[1] = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (bus1.ready !== 1'b0 || bus1.error !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: ready=%b error=%b expected 0/0", c, bus1.ready, bus1.error);
            end
        end
    endtask

    task automatic test_write_ws1();
        int lat, pulses; logic err; logic [63:0] rd, ee; logic exp_err;
        run_txn(1, 32'h10, 1'b1, DEAD, 0, lat, pulses, err, rd);
        model_txn(1, 32'h10, 1'b1, DEAD, exp_err, ee);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d expected 2", lat); end
        n_tests++;
        if (pulses !== 1) begin n_fail++; $display("FAIL wr_pulses: got %0d expected 1", pulses); end
        n_tests++;
        if (err !== exp_err) begin n_fail++; $display("FAIL wr_error: got %b expected %b", err, exp_err); end
        n_tests++;
        if (rd !== FLOAT) begin n_fail++; $display("FAIL wr_bus: got %h expected %h", rd, FLOAT); end
    endtask

    task automatic test_read_oe();
        logic [63:0] mid; bit seen;
        seen = 1'b0; mid = '0;
        @(negedge clk);
        addr_v[1] = 32'h10; we_v[1] = 1'b0; oe_v[1] = 1'b1; cs_v[1] = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) mid = data1;
            if (bus1.ready) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rd_ready_timeout: got none expected pulse"); end
        n_tests++;
        if (mid !== DEAD) begin n_fail++; $display("FAIL rd_access_data: got %h expected %h", mid, DEAD); end
        n_tests++;
        if (data1 !== DEAD) begin n_fail++; $display("FAIL rd_ready_data: got %h expected %h", data1, DEAD); end
        oe_v[1] = 1'b0; #1;
        n_tests++;
        if (data1 !== FLOAT) begin n_fail++; $display("FAIL rd_oe_off: got %h expected %h", data1, FLOAT); end
        oe_v[1] = 1'b1; #1;
        n_tests++;
        if (data1 !== DEAD) begin n_fail++; $display("FAIL rd_oe_on: got %h expected %h", data1, DEAD); end
        @(negedge clk);
        n_tests++;
        if (data1 !== DEAD || bus1.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_hold: data=%h ready=%b expected %h/0", data1, bus1.ready, DEAD);
        end
        cs_v[1] = 1'b0;
        @(negedge clk);
        n_tests++;
        if (data1 !== FLOAT) begin n_fail++; $display("FAIL rd_release: got %h expected %h", data1, FLOAT); end
        oe_v[1] = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] addrs [5];
        logic        wrs   [5];
        int lat, pulses; logic err, exp_err; logic [63:0] rd, exp_dat, wv;
        addrs = '{32'h13, 32'h800, 32'h14, 32'h810, 32'h10};
        wrs   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            wv = {$urandom, $urandom};
            run_txn(1, addrs[i], wrs[i], wv, 0, lat, pulses, err, rd);
            model_txn(1, addrs[i], wrs[i], wv, exp_err, exp_dat);
            n_tests++;
            if (lat !== 2 || pulses !== 1 || err !== exp_err || rd !== exp_dat) begin
                n_fail++;
                $display("FAIL err_case%0d @%h: lat=%0d pulses=%0d err=%b data=%h expected 2/1/%b/%h",
                         i, addrs[i], lat, pulses, err, rd, exp_err, exp_dat);
            end
        end
    endtask

    task automatic test_hold();
        int lat, pulses; logic err; logic [63:0] rd;
        run_txn(1, 32'h10, 1'b0, '0, 10, lat, pulses, err, rd);
        n_tests++;
        if (pulses !== 1 || lat !== 2 || rd !== mref[1][2]) begin
            n_fail++;
            $display("FAIL hold_single_pulse: pulses=%0d lat=%0d data=%h expected 1/2/%h", pulses, lat, rd, mref[1][2]);
        end
    endtask

    task automatic test_ws0_top();
        logic [31:0] addrs [6];
        logic        wrs   [6];
        int lat, pulses; logic err, exp_err; logic [63:0] rd, exp_dat, wv;
        addrs = '{32'h000, 32'h7F0, 32'h7F8, 32'h000, 32'h7F0, 32'h7F8};
        wrs   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            wv = {$urandom, $urandom};
            run_txn(0, addrs[i], wrs[i], wv, 0, lat, pulses, err, rd);
            model_txn(0, addrs[i], wrs[i], wv, exp_err, exp_dat);
            n_tests++;
            if (lat !== 1 || pulses !== 1 || err !== exp_err || rd !== exp_dat) begin
                n_fail++;
                $display("FAIL ws0_case%0d @%h: lat=%0d pulses=%0d err=%b data=%h expected 1/1/%b/%h",
                         i, addrs[i], lat, pulses, err, rd, exp_err, exp_dat);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int lat, pulses; logic err, exp_err; logic [63:0] rd, exp_dat, oldv;
        oldv = {$urandom, $urandom};
        run_txn(1, 32'h18, 1'b1, oldv, 0, lat, pulses, err, rd);
        model_txn(1, 32'h18, 1'b1, oldv, exp_err, exp_dat);
        @(negedge clk);
        addr_v[1] = 32'h18; we_v[1] = 1'b1; wd_v[1] = ~oldv; wdrv_v[1] = 1'b1; cs_v[1] = 1'b1;
        @(negedge clk);
        rst = 1'b1; wdrv_v[1] = 1'b0;
        pulses = 0;
        @(negedge clk);
        cs_v[1] = 1'b0; we_v[1] = 1'b0; rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus1.ready) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin n_fail++; $display("FAIL rst_mid_pulse: got %0d expected 0", pulses); end
        run_txn(1, 32'h18, 1'b0, '0, 0, lat, pulses, err, rd);
        model_txn(1, 32'h18, 1'b0, '0, exp_err, exp_dat);
        n_tests++;
        if (rd !== exp_dat || lat !== 2 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_mem: data=%h lat=%0d err=%b expected %h/2/0", rd, lat, err, exp_dat);
        end
    endtask

    task automatic test_random();
        int lat, pulses, kind, d; logic err, exp_err, w; logic [63:0] rd, exp_dat, wv;
        logic [31:0] a; logic [7:0] idx8;
        for (int i = 0; i < 60; i++) begin
            d    = i % 2;
            kind = $urandom_range(0, 9);
            idx8 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
            w    = $urandom_range(0, 1) == 1;
            wv   = {$urandom, $urandom};
            if (kind == 0)      a = {21'h0, idx8, 3'($urandom_range(1, 7))};
            else if (kind == 1) a = ($urandom | 32'h800) & ~32'h7;
            else                a = {21'h0, idx8, 3'b000};
            if (!w && addr_ok(a) && !mknown[d][widx(a)]) w = 1'b1;
            run_txn(d, a, w, wv, $urandom_range(0, 2), lat, pulses, err, rd);
            model_txn(d, a, w, wv, exp_err, exp_dat);
            n_tests++;
            if (lat !== d + 1 || pulses !== 1 || err !== exp_err || rd !== exp_dat) begin
                n_fail++;
                $display("FAIL rand%0d dut%0d %s @%h: lat=%0d pulses=%0d err=%b data=%h expected %0d/1/%b/%h",
                         i, d, w ? "wr" : "rd", a, lat, pulses, err, rd, d + 1, exp_err, exp_dat);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            addr_v[d] = '0; cs_v[d] = 1'b0; we_v[d] = 1'b0; oe_v[d] = 1'b0;
            wdrv_v[d] = 1'b0; wd_v[d] = '0;
            for (int k = 0; k < 256; k++) begin
                mref[d][k] = '0; mknown[d][k] = 1'b0;
            end
        end
        rst = 1'b1;
        test_reset();
        test_write_ws1();
        test_read_oe();
        test_errors();
        test_hold();
        test_ws0_top();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
